// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: the hazard sequencer
// state encoding, architectural constants and a small register-compare helper.
package pipe_ctrl_pkg;

    localparam int XLEN = 32;
    localparam logic [4:0] REG_X0 = 5'd0;

    // The memory-wait counter saturates instead of wrapping, so a very long
    // stall can never make the timeout logic see a small count again.
    localparam int WAIT_CNT_W = 8;
    localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_SAT = 8'd255;

    // Wide enough for a flush window of up to four cycles.
    localparam int FCNT_W = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_e;

    // A source register is a hazard candidate only if the instruction reads it
    // and it names the register the load is about to write.
    function automatic logic srcMatches(input logic usesSrc,
                                        input logic [4:0] srcReg,
                                        input logic [4:0] dstReg);
        return usesSrc && (srcReg == dstReg);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Purely combinational load-use hazard compare between the instruction in ID
// and a load sitting in EX. Kept separate so a forwarding unit can reuse it.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       i_exMemRead,
    input  logic [4:0] i_exRd,
    input  logic [4:0] i_idRs1,
    input  logic [4:0] i_idRs2,
    input  logic       i_idUseRs1,
    input  logic       i_idUseRs2,
    output logic       o_loadUse
);

    // A load into x0 never produces a value anyone can consume, so it is not
    // a hazard even when the register numbers line up.
    always_comb begin
        o_loadUse = i_exMemRead
                 && (i_exRd != REG_X0)
                 && (srcMatches(i_idUseRs1, i_idRs1, i_exRd)
                  || srcMatches(i_idUseRs2, i_idRs2, i_exRd));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// control-flow redirects resolved in MEM, and whole-pipe hold on data-memory
// wait with a sticky timeout flag.
// Optional performance counters are built when PIPE_HAZ_PERF_EN is defined;
// otherwise stall_cnt/flush_cnt are tied to zero and no counter flops exist.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int WAIT_MAX     = 15
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    input  logic            mem_branch,
    input  logic            mem_zero,
    input  logic            mem_jal,
    input  logic            mem_jalr,
    input  logic [XLEN-1:0] mem_target,
    input  logic            dmem_req,
    input  logic            dmem_ready,
    output logic            pc_write,
    output logic            if_id_write,
    output logic            hold,
    output logic            if_flush,
    output logic            id_flush,
    output logic            ex_flush,
    output logic            pc_sel,
    output logic [XLEN-1:0] redirect_pc,
    output logic            mem_timeout,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
);

    localparam logic [FCNT_W-1:0]     FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT  = WAIT_CNT_W'(WAIT_MAX);

    ctrl_state_e           r_state;
    ctrl_state_e           w_stateNext;
    logic [FCNT_W-1:0]     r_fcnt;
    logic [FCNT_W-1:0]     w_fcntNext;
    logic [WAIT_CNT_W-1:0] r_waitCnt;
    logic [WAIT_CNT_W-1:0] w_waitCntNext;
    logic                  r_timeout;
    logic                  w_timeoutNext;
    logic [XLEN-1:0]       r_redirectPc;

    logic w_redirect;
    logic w_mwait;
    logic w_loadUse;

    // Load-use compare lives in its own block so it can be shared later.
    load_use_detect u_loadUse (
        .i_exMemRead (ex_mem_read),
        .i_exRd      (ex_rd),
        .i_idRs1     (id_rs1),
        .i_idRs2     (id_rs2),
        .i_idUseRs1  (id_use_rs1),
        .i_idUseRs2  (id_use_rs2),
        .o_loadUse   (w_loadUse)
    );

    // Same-cycle hazard events seen by the sequencer.
    always_comb begin
        w_redirect = (mem_branch && mem_zero) || mem_jal || mem_jalr;
        w_mwait    = dmem_req && !dmem_ready;
    end

    // Next-state and output decode; memory wait beats redirect beats load-use.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        hold          = 1'b0;
        if_flush      = 1'b0;
        id_flush      = 1'b0;
        ex_flush      = 1'b0;
        pc_sel        = 1'b0;
        w_stateNext   = r_state;
        w_fcntNext    = r_fcnt;
        w_waitCntNext = r_waitCnt;
        w_timeoutNext = r_timeout;

        if (w_mwait) begin
            // Freeze everything; a flush window in progress is abandoned and
            // a redirect waiting in MEM is picked up once memory answers.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            hold        = 1'b1;
            w_stateNext = MEM_WAIT;
            w_fcntNext  = '0;
            if (r_state == MEM_WAIT) begin
                w_waitCntNext = (r_waitCnt == WAIT_CNT_SAT) ? r_waitCnt
                                                            : r_waitCnt + 1'b1;
            end else begin
                w_waitCntNext = WAIT_CNT_W'(1);
            end
            if (w_waitCntNext >= WAIT_LIMIT) begin
                w_timeoutNext = 1'b1;
            end
        end else if (r_state == FLUSH) begin
            // Keep squashing the wrong-path instructions still in flight.
            if_flush      = 1'b1;
            id_flush      = 1'b1;
            ex_flush      = 1'b1;
            w_waitCntNext = '0;
            if (w_redirect) begin
                pc_sel     = 1'b1;
                w_fcntNext = FCNT_RELOAD;
            end else if (r_fcnt <= FCNT_W'(1)) begin
                w_fcntNext  = '0;
                w_stateNext = RUN;
            end else begin
                w_fcntNext = r_fcnt - 1'b1;
            end
        end else begin
            // RUN, or the cycle memory finally answers out of MEM_WAIT: both
            // resolve redirect and load-use normally in this same cycle.
            w_waitCntNext = '0;
            w_stateNext   = RUN;
            if (w_redirect) begin
                pc_sel   = 1'b1;
                if_flush = 1'b1;
                id_flush = 1'b1;
                ex_flush = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    w_stateNext = FLUSH;
                    w_fcntNext  = FCNT_RELOAD;
                end
            end else if (w_loadUse) begin
                // One bubble is enough: the load moves to MEM next cycle.
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_flush    = 1'b1;
            end
        end
    end

    // Sequencer state, flush/wait counters, sticky timeout and last target.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_fcnt       <= '0;
            r_waitCnt    <= '0;
            r_timeout    <= 1'b0;
            r_redirectPc <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_fcnt    <= w_fcntNext;
            r_waitCnt <= w_waitCntNext;
            r_timeout <= w_timeoutNext;
            if (pc_sel) begin
                r_redirectPc <= mem_target;
            end
        end
    end

    // The target is passed straight through on a redirect and otherwise
    // holds the last one issued, so downstream never sees it wander.
    always_comb begin
        redirect_pc = pc_sel ? mem_target : r_redirectPc;
        mem_timeout = r_timeout;
    end

`ifdef PIPE_HAZ_PERF_EN
    logic [31:0] r_stallCnt;
    logic [31:0] r_flushCnt;

    // Free-running stall and redirect counters that wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (!pc_write) begin
                r_stallCnt <= r_stallCnt + 32'd1;
            end
            if (pc_sel) begin
                r_flushCnt <= r_flushCnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stallCnt;
    assign flush_cnt = r_flushCnt;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push their
// hand-computed expected outputs into a queue and a monitor compares them
// against the DUT on the falling edge of the same cycle.
module tb_pipeline_hazard_ctrl;

    localparam int FC = 3;
    localparam int WM = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read;
    logic        mem_branch, mem_zero, mem_jal, mem_jalr;
    logic [31:0] mem_target;
    logic        dmem_req, dmem_ready;
    logic        pc_write, if_id_write, hold, if_flush, id_flush, ex_flush, pc_sel;
    logic [31:0] redirect_pc;
    logic        mem_timeout;
    logic [31:0] stall_cnt, flush_cnt;

    typedef struct {
        logic        rst;
        logic [4:0]  idRs1;
        logic [4:0]  idRs2;
        logic        useRs1;
        logic        useRs2;
        logic        exMemRead;
        logic [4:0]  exRd;
        logic        memBranch;
        logic        memZero;
        logic        memJal;
        logic        memJalr;
        logic [31:0] memTarget;
        logic        dmemReq;
        logic        dmemReady;
    } stim_t;

    typedef struct {
        int          id;
        logic        pcWrite;
        logic        ifIdWrite;
        logic        hold;
        logic        ifFlush;
        logic        idFlush;
        logic        exFlush;
        logic        pcSel;
        logic [31:0] redirectPc;
        logic        memTimeout;
        logic [31:0] stallCnt;
        logic [31:0] flushCnt;
    } exp_t;

    int    checks = 0;
    int    errors = 0;
    int    vecId = 0;
    int    expStall = 0;
    int    expFlush = 0;
    exp_t  expQ[$];
    stim_t s;

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES (FC),
        .WAIT_MAX     (WM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .mem_branch  (mem_branch),
        .mem_zero    (mem_zero),
        .mem_jal     (mem_jal),
        .mem_jalr    (mem_jalr),
        .mem_target  (mem_target),
        .dmem_req    (dmem_req),
        .dmem_ready  (dmem_ready),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .hold        (hold),
        .if_flush    (if_flush),
        .id_flush    (id_flush),
        .ex_flush    (ex_flush),
        .pc_sel      (pc_sel),
        .redirect_pc (redirect_pc),
        .mem_timeout (mem_timeout),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    function automatic stim_t idleS();
        stim_t v;
        v.rst = 1'b0; v.idRs1 = '0; v.idRs2 = '0; v.useRs1 = 1'b0; v.useRs2 = 1'b0;
        v.exMemRead = 1'b0; v.exRd = '0; v.memBranch = 1'b0; v.memZero = 1'b0;
        v.memJal = 1'b0; v.memJalr = 1'b0; v.memTarget = '0;
        v.dmemReq = 1'b0; v.dmemReady = 1'b0;
        return v;
    endfunction

    function automatic exp_t normE(input logic [31:0] rpc, input logic to);
        exp_t e;
        e.id = 0; e.pcWrite = 1'b1; e.ifIdWrite = 1'b1; e.hold = 1'b0;
        e.ifFlush = 1'b0; e.idFlush = 1'b0; e.exFlush = 1'b0; e.pcSel = 1'b0;
        e.redirectPc = rpc; e.memTimeout = to; e.stallCnt = '0; e.flushCnt = '0;
        return e;
    endfunction

    function automatic exp_t stallE(input logic [31:0] rpc, input logic to);
        exp_t e = normE(rpc, to);
        e.pcWrite = 1'b0; e.ifIdWrite = 1'b0; e.hold = 1'b1;
        return e;
    endfunction

    function automatic exp_t bubbleE(input logic [31:0] rpc, input logic to);
        exp_t e = normE(rpc, to);
        e.pcWrite = 1'b0; e.ifIdWrite = 1'b0; e.idFlush = 1'b1;
        return e;
    endfunction

    function automatic exp_t flushE(input logic [31:0] rpc, input logic to, input logic sel);
        exp_t e = normE(rpc, to);
        e.ifFlush = 1'b1; e.idFlush = 1'b1; e.exFlush = 1'b1; e.pcSel = sel;
        return e;
    endfunction

    // Drive one cycle of inputs just after the rising edge and queue what the
    // DUT must show during that cycle; reset cycles are not scored.
    task automatic applyStimulus(input stim_t v, input exp_t e);
        @(posedge clk);
        #1;
        rst = v.rst; id_rs1 = v.idRs1; id_rs2 = v.idRs2;
        id_use_rs1 = v.useRs1; id_use_rs2 = v.useRs2;
        ex_mem_read = v.exMemRead; ex_rd = v.exRd;
        mem_branch = v.memBranch; mem_zero = v.memZero;
        mem_jal = v.memJal; mem_jalr = v.memJalr; mem_target = v.memTarget;
        dmem_req = v.dmemReq; dmem_ready = v.dmemReady;
        if (v.rst) begin
            expStall = 0;
            expFlush = 0;
        end else begin
            e.id = vecId;
            vecId++;
`ifdef PIPE_HAZ_PERF_EN
            e.stallCnt = expStall;
            e.flushCnt = expFlush;
`else
            e.stallCnt = '0;
            e.flushCnt = '0;
`endif
            expQ.push_back(e);
            if (!e.pcWrite) expStall++;
            if (e.pcSel) expFlush++;
        end
    endtask

    task automatic checkOutput(input string name, input int id,
                               input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s vec %0d actual 0x%0h required 0x%0h", name, id, act, req);
        end
    endtask

    // Monitor: whenever an expectation is pending, score the DUT mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("pc_write",    e.id, 32'(pc_write),    32'(e.pcWrite));
                checkOutput("if_id_write", e.id, 32'(if_id_write), 32'(e.ifIdWrite));
                checkOutput("hold",        e.id, 32'(hold),        32'(e.hold));
                checkOutput("if_flush",    e.id, 32'(if_flush),    32'(e.ifFlush));
                checkOutput("id_flush",    e.id, 32'(id_flush),    32'(e.idFlush));
                checkOutput("ex_flush",    e.id, 32'(ex_flush),    32'(e.exFlush));
                checkOutput("pc_sel",      e.id, 32'(pc_sel),      32'(e.pcSel));
                checkOutput("redirect_pc", e.id, redirect_pc,      e.redirectPc);
                checkOutput("mem_timeout", e.id, 32'(mem_timeout), 32'(e.memTimeout));
                checkOutput("stall_cnt",   e.id, stall_cnt,        e.stallCnt);
                checkOutput("flush_cnt",   e.id, flush_cnt,        e.flushCnt);
            end
        end
    end

    // Watchdog so a wedged run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed vector sequence.
    initial begin
        int drain;
        s = idleS();
        s.rst = 1'b1;
        rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = '0; mem_branch = 1'b0; mem_zero = 1'b0;
        mem_jal = 1'b0; mem_jalr = 1'b0; mem_target = '0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
        applyStimulus(s, normE(32'h0, 1'b0));
        applyStimulus(s, normE(32'h0, 1'b0));

        s = idleS(); applyStimulus(s, normE(32'h0, 1'b0));

        s = idleS(); s.exMemRead = 1'b1; s.exRd = 5'd5; s.idRs1 = 5'd5; s.useRs1 = 1'b1;
        applyStimulus(s, bubbleE(32'h0, 1'b0));
        s.exMemRead = 1'b0;
        applyStimulus(s, normE(32'h0, 1'b0));

        s = idleS(); s.exMemRead = 1'b1; s.exRd = 5'd0; s.idRs1 = 5'd0; s.useRs1 = 1'b1;
        applyStimulus(s, normE(32'h0, 1'b0));

        s = idleS(); s.exMemRead = 1'b1; s.exRd = 5'd7; s.idRs1 = 5'd3; s.useRs1 = 1'b1;
        s.idRs2 = 5'd7; s.useRs2 = 1'b1;
        applyStimulus(s, bubbleE(32'h0, 1'b0));
        s.useRs2 = 1'b0;
        applyStimulus(s, normE(32'h0, 1'b0));

        s = idleS(); s.memBranch = 1'b1; s.memZero = 1'b1; s.memTarget = 32'h40;
        applyStimulus(s, flushE(32'h40, 1'b0, 1'b1));
        s = idleS();
        applyStimulus(s, flushE(32'h40, 1'b0, 1'b0));
        applyStimulus(s, flushE(32'h40, 1'b0, 1'b0));
        applyStimulus(s, normE(32'h40, 1'b0));

        s = idleS(); s.memBranch = 1'b1; s.memZero = 1'b0; s.memTarget = 32'h44;
        applyStimulus(s, normE(32'h40, 1'b0));

        s = idleS(); s.dmemReq = 1'b1; s.memJal = 1'b1; s.memTarget = 32'h80;
        for (int i = 0; i < 4; i++) applyStimulus(s, stallE(32'h40, 1'b0));
        s.dmemReady = 1'b1;
        applyStimulus(s, flushE(32'h80, 1'b0, 1'b1));
        s = idleS();
        applyStimulus(s, flushE(32'h80, 1'b0, 1'b0));
        s = idleS(); s.memJalr = 1'b1; s.memTarget = 32'hC0;
        applyStimulus(s, flushE(32'hC0, 1'b0, 1'b1));
        s = idleS();
        applyStimulus(s, flushE(32'hC0, 1'b0, 1'b0));
        s = idleS(); s.dmemReq = 1'b1;
        applyStimulus(s, stallE(32'hC0, 1'b0));
        s.dmemReady = 1'b1; s.exMemRead = 1'b1; s.exRd = 5'd9; s.idRs1 = 5'd9; s.useRs1 = 1'b1;
        applyStimulus(s, bubbleE(32'hC0, 1'b0));
        s = idleS();
        applyStimulus(s, normE(32'hC0, 1'b0));

        s = idleS(); s.dmemReq = 1'b1;
        for (int i = 1; i <= 20; i++) applyStimulus(s, stallE(32'hC0, (i >= WM + 1)));
        s = idleS();
        applyStimulus(s, normE(32'hC0, 1'b1));
        applyStimulus(s, normE(32'hC0, 1'b1));

        s = idleS(); s.memBranch = 1'b1; s.memZero = 1'b1; s.memTarget = 32'h100;
        applyStimulus(s, flushE(32'h100, 1'b1, 1'b1));
        s = idleS();
        applyStimulus(s, flushE(32'h100, 1'b1, 1'b0));
        s.rst = 1'b1;
        applyStimulus(s, normE(32'h0, 1'b0));
        s = idleS();
        applyStimulus(s, normE(32'h0, 1'b0));
        applyStimulus(s, normE(32'h0, 1'b0));

        drain = 0;
        while (expQ.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain actual %0d pending required 0 pending", expQ.size());
        end
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It detects load-use hazards in ID and resolves control-flow redirects from branch/jal/jalr in MEM. It also holds the whole pipeline while data memory is not ready.
It drives PC write-enable, IF_ID write-enable, the per-stage flush inputs of IF_ID, ID_EX and EX_MEM (EX_flush), and the PC redirect mux.

Parameters:
FLUSH_CYCLES, 1, cycles the flush signals stay asserted after a redirect (1..4)
WAIT_MAX, 15, max consecutive memory-wait cycles before mem_timeout asserts (1..255)

Ports:
clk  in  1  pipeline clock, rising edge for this block
rst  in  1  synchronous active-high reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  5  destination register of EX instruction
mem_branch  in  1  EX_MEM Branch_out
mem_zero  in  1  EX_MEM zero_out
mem_jal  in  1  EX_MEM jal_out
mem_jalr  in  1  EX_MEM jalr_out
mem_target  in  32  resolved target address from MEM
dmem_req  in  1  MEM stage accessing data memory this cycle
dmem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC register enable
if_id_write  out  1  IF_ID enable
hold  out  1  freeze ID_EX, EX_MEM, MEM_WB
if_flush  out  1  IF_ID flush
id_flush  out  1  ID_EX flush (bubble insert)
ex_flush  out  1  EX_MEM flush
pc_sel  out  1  1 = PC loads redirect_pc
redirect_pc  out  32  next PC on redirect
mem_timeout  out  1  sticky, memory wait exceeded WAIT_MAX
stall_cnt  out  32  stall cycles (optional feature)
flush_cnt  out  32  redirect events (optional feature)

Behaviour:
- States: RUN, FLUSH, MEM_WAIT. Reset: state=RUN, counters=0, mem_timeout=0. All outputs at reset: pc_write=1, if_id_write=1, hold=0, flushes=0, pc_sel=0, redirect_pc=0.
- Events are combinational in the same cycle:
  - redirect = (mem_branch & mem_zero) | mem_jal | mem_jalr
  - mwait = dmem_req & ~dmem_ready
  - lu = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))
- Priority: mwait > redirect > lu.
- RUN, mwait: pc_write=0, if_id_write=0, hold=1, no flush. Next state MEM_WAIT, wait_cnt=1.
- RUN, redirect: pc_sel=1, redirect_pc=mem_target, if_flush=id_flush=ex_flush=1 this cycle.
  - If FLUSH_CYCLES>1: go to FLUSH with fcnt=FLUSH_CYCLES-1.
- RUN, lu: pc_write=0, if_id_write=0, id_flush=1 (one bubble). Stays RUN; the hazard clears next cycle because the load has advanced.
- MEM_WAIT: same outputs as mwait while mwait holds; wait_cnt increments and saturates at 255.
  - When wait_cnt reaches WAIT_MAX, mem_timeout sets and stays set until rst.
  - On dmem_ready: release hold this cycle, return to RUN, and evaluate redirect/lu normally in the same cycle.
- FLUSH: all three flushes=1, pc_write=1, pc_sel=0. Decrement fcnt; at 0 go to RUN.
  - A new redirect in FLUSH reloads fcnt and drives pc_sel=1.
  - An mwait in FLUSH takes priority: go to MEM_WAIT and discard the remaining flush count.
- rst mid-operation overrides everything next edge: state=RUN, counters cleared.
- redirect_pc holds its last value when pc_sel=0.

Optional Feature:
PIPE_HAZ_PERF_EN:
- Defined: stall_cnt counts cycles where pc_write=0; flush_cnt counts cycles where pc_sel=1. Both wrap modulo 2^32 and clear on rst.
- Undefined: both outputs are constant 0 and no counter flops are built.

Decomposition:
- Shared package pipe_ctrl_pkg holds the state enum (RUN/FLUSH/MEM_WAIT), the REG_X0 constant and the XLEN=32 constant.
- One natural sub-module, load_use_detect: the purely combinational lu compare, reusable by a future forwarding unit.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> for 1 cycle pc_write=0, if_id_write=0, id_flush=1; next cycle (ex_mem_read=0) all normal.
- x0 load: ex_rd=0, id_rs1=0 -> no stall.
- Taken branch: mem_branch=1, mem_zero=1, mem_target=0x40 -> same cycle pc_sel=1, redirect_pc=0x40, all flushes=1. With FLUSH_CYCLES=3, flushes stay high 2 more cycles.
- Memory wait with redirect: dmem_req=1, dmem_ready=0 for 4 cycles while mem_jal=1 -> hold=1, pc_sel=0 throughout. Cycle dmem_ready=1 -> hold=0, pc_sel=1.
- Timeout: WAIT_MAX=15, dmem_ready low 20 cycles -> mem_timeout rises on the 15th wait cycle and stays high until rst.
- Reset mid-FLUSH: rst pulse during FLUSH -> next cycle state RUN, flushes=0, stall_cnt/flush_cnt=0 (with PIPE_HAZ_PERF_EN).
